ibus_mem_responder: RTL and testbench
=====================================

Name: ibus_mem_responder

Overview:
- Instruction-bus responder: the target end of the cyc/adr/ack/rdt iBus that the arbiter drives on its controlled-device side.
- Serves 32-bit word reads from an internal synchronous memory with a programmable wait-state count.
- Acks exactly once per transaction, then holds a one-cycle post-ack pause.
- Has a side-band load port so boot logic can fill the memory before the CPU is released.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- ADDR_WIDTH, 10: log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- WAIT_STATES, 1: extra cycles inserted between read issue and ack; legal range 0..15.

Ports:
- wb_clk  in  1  system clock; all logic on the rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- i_cyc  in  1  bus request from the initiator/arbiter; held high until ack.
- i_adr  in  32  byte address; bits [1:0] ignored.
- o_ack  out  1  one-cycle read-complete strobe.
- o_rdt  out  32  read data; valid only while o_ack=1, forced to 0 otherwise.
- o_err  out  1  pulses together with o_ack when the address was out of range.
- ld_en  in  1  memory write strobe for the load port.
- ld_adr  in  ADDR_WIDTH  word index to write.
- ld_dat  in  32  word to write.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ack=0, o_rdt=0, o_err=0, wait counter=0. Memory contents are not cleared. Reset mid-transaction abandons the request; no ack is issued.
- States: IDLE, WAIT, ACK, PAUSE.
- Address decode:
  - word = i_adr[31:2] - BASE_ADDR[31:2].
  - In range iff i_adr[31:2] >= BASE_ADDR[31:2] and word < 2^ADDR_WIDTH.
  - Compare at 30-bit width; no wrap-around across 2^32.
- IDLE:
  - If i_cyc=1 and ld_en=0: latch the address/in-range flag, issue the memory read, load counter=WAIT_STATES, then go to WAIT if WAIT_STATES>0, else ACK.
  - If ld_en=1: perform the load write; a pending i_cyc stays in IDLE (load has priority, single-port RAM).
- WAIT:
  - Counter decrements each cycle; go to ACK when it reaches 1.
  - If i_cyc drops: abort to IDLE, no ack.
  - ld_en in WAIT/ACK/PAUSE is still written; a write to the word currently being read does not change the already-issued read data.
- ACK (exactly one cycle):
  - o_ack = i_cyc.
  - o_rdt = read data if in range, else 0.
  - o_err = i_cyc & !in_range.
  - Always go to PAUSE.
- PAUSE (one cycle): i_cyc ignored and o_ack=0; go to IDLE.
  - Back-to-back requests therefore start no earlier than 2 cycles after the ack.
- Latency: i_cyc first sampled high in IDLE at edge N gives o_ack high in the cycle after edge N+WAIT_STATES, i.e. WAIT_STATES+1 cycles.
- i_adr changes after the request edge are ignored (the address is latched).
- o_ack, o_rdt and o_err are derived from registered state gated with i_cyc. No combinational path from i_adr to o_rdt.
- Never more than one ack per i_cyc assertion. Ack never issued while i_cyc=0.

Test Plan:
- Reset/idle:
  - Stimulus: hold wb_rst_n=0, drive i_cyc=1, i_adr=0.
  - Required: o_ack=0, o_rdt=0, o_err=0 throughout.
  - Stimulus: release reset.
  - Required: first ack after WAIT_STATES+1 cycles.
- Load then read, WAIT_STATES=1:
  - Stimulus: load word 5 = 32'hDEADBEEF; i_cyc=1, i_adr=BASE+32'h14.
  - Required: o_ack high exactly at cycle 2, o_rdt=32'hDEADBEEF, o_err=0; o_ack low at cycle 3 (PAUSE).
- Zero wait states:
  - Stimulus: WAIT_STATES=0, word 0 = 32'h00000013, i_adr=BASE.
  - Required: ack in the cycle after the request edge.
  - Stimulus: keep i_cyc high continuously.
  - Required: next ack 3 cycles later.
- Out of range, ADDR_WIDTH=10:
  - Stimulus: i_adr = BASE+32'h1000.
  - Required: o_ack=1, o_err=1, o_rdt=0.
  - Stimulus: i_adr = BASE-4.
  - Required: same response.
- Abort and collision:
  - Stimulus: WAIT_STATES=3, drop i_cyc after 1 cycle.
  - Required: no ack; return to IDLE.
  - Stimulus: ld_en and i_cyc together in IDLE.
  - Required: write completes first; read starts one cycle later and returns the new data.
- Reset mid-WAIT:
  - Stimulus: assert wb_rst_n=0 during WAIT.
  - Required: immediate o_ack=0, state IDLE, previously loaded memory word still reads back correctly.

Source files
------------

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder
// Target end of the cyc/adr/ack/rdt instruction bus. Serves 32-bit word reads
// from an internal synchronous memory after a fixed number of wait states.
// It acks once per request and then holds a one-cycle pause. A side-band load
// port lets boot logic fill the memory before the CPU is released.

module ibus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000, // byte address of word 0, 4-byte aligned
  parameter int          ADDR_WIDTH  = 10,            // log2 of memory depth in words
  parameter int          WAIT_STATES = 1              // 0..15 extra cycles before ack
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  i_cyc,
  input  logic [31:0]           i_adr,
  output logic                  o_ack,
  output logic [31:0]           o_rdt,
  output logic                  o_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_adr,
  input  logic [31:0]           ld_dat
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            in_range_p1;
  logic [31:0]     rd_dat_p1;
  logic [31:0]     mem [DEPTH];

  logic [29:0]     req_word;
  logic [29:0]     word_off;
  logic            req_in_range;
  logic            rd_req;
  logic            ack_gate;

  // The window test is done at 30-bit word granularity. The offset is widened
  // by one bit before the depth compare, so ADDR_WIDTH up to 30 still works.
  // An address below the base fails the first term. Its offset would have
  // wrapped, so it is never treated as in range.
  function automatic logic word_in_range(input logic [29:0] adr_word,
                                         input logic [29:0] off);
    logic [30:0] depth_w;
    depth_w = 31'd1 << ADDR_WIDTH;
    return (adr_word >= BASE_WORD) && ({1'b0, off} < depth_w);
  endfunction

  assign req_word     = i_adr[31:2];
  assign word_off     = req_word - BASE_WORD;
  assign req_in_range = word_in_range(req_word, word_off);

  // The RAM is single-ported, so a load in IDLE holds off the read issue.
  // The read is only issued in IDLE and the write never competes with it.
  assign rd_req = (state == IDLE) && i_cyc && !ld_en;

  // Stage p0 -> p1: memory write port and registered read issue. A later
  // load to the same word cannot disturb the captured read data.
  always_ff @(posedge wb_clk) begin
    if (ld_en) begin
      mem[ld_adr] <= ld_dat;
    end
    if (rd_req) begin
      rd_dat_p1 <= mem[word_off[ADDR_WIDTH-1:0]];
    end
  end

  // Control FSM: latch the request, count the wait states, ack for one cycle, then pause.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      in_range_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            in_range_p1 <= req_in_range;
            wait_cnt    <= WS;
            state       <= (WS == 4'd0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!i_cyc) begin
            // The initiator walked away. Drop the request without acking.
            wait_cnt <= 4'd0;
            state    <= IDLE;
          end else if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state <= PAUSE;
        end
        PAUSE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The ack is gated by the live i_cyc, so it never fires after the initiator drops the request.
  assign ack_gate = (state == ACK) && i_cyc;

  // Bus outputs are built from registered state only. i_adr has no path to o_rdt.
  always_comb begin
    o_ack = ack_gate;
    o_err = ack_gate && !in_range_p1;
    o_rdt = 32'd0;
    if (ack_gate && in_range_p1) begin
      o_rdt = rd_dat_p1;
    end
  end

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Directed bench for ibus_mem_responder. It uses three instances that differ
// only in wait-state count: [0]=1, [1]=0, [2]=3. All share the clock and reset.
// Inputs change on the falling edge, and outputs are checked on the falling edge.

module tb_ibus_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        cyc    [3];
  logic [31:0] adr    [3];
  logic        ld_en  [3];
  logic [9:0]  ld_adr [3];
  logic [31:0] ld_dat [3];
  logic        ack    [3];
  logic [31:0] rdt    [3];
  logic        err    [3];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibus_mem_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_cyc(cyc[0]), .i_adr(adr[0]),
    .o_ack(ack[0]), .o_rdt(rdt[0]), .o_err(err[0]),
    .ld_en(ld_en[0]), .ld_adr(ld_adr[0]), .ld_dat(ld_dat[0]));

  ibus_mem_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_cyc(cyc[1]), .i_adr(adr[1]),
    .o_ack(ack[1]), .o_rdt(rdt[1]), .o_err(err[1]),
    .ld_en(ld_en[1]), .ld_adr(ld_adr[1]), .ld_dat(ld_dat[1]));

  ibus_mem_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_cyc(cyc[2]), .i_adr(adr[2]),
    .o_ack(ack[2]), .o_rdt(rdt[2]), .o_err(err[2]),
    .ld_en(ld_en[2]), .ld_adr(ld_adr[2]), .ld_dat(ld_dat[2]));

  // Advance from one falling edge to the next, passing exactly one rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d]    = 1'b0;
      adr[d]    = 32'd0;
      ld_en[d]  = 1'b0;
      ld_adr[d] = 10'd0;
      ld_dat[d] = 32'd0;
    end

    // Reset held with a request pending: all outputs stay quiet.
    cyc[0] = 1'b1;
    adr[0] = 32'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_rdt", rdt[0], 32'd0);
      chk("rst_err", 32'(err[0]), 32'd0);
    end

    // Reset released: the first ack arrives WAIT_STATES+1 = 2 cycles later, then the pause.
    rst_n = 1'b1;
    step(); chk("rel_ack_c1", 32'(ack[0]), 32'd0);
    step(); chk("rel_ack_c2", 32'(ack[0]), 32'd1);
    step(); chk("rel_pause", 32'(ack[0]), 32'd0);
    cyc[0] = 1'b0;
    step();

    // Load word 5, then read it with one wait state.
    ld_en[0] = 1'b1; ld_adr[0] = 10'd5; ld_dat[0] = 32'hDEAD_BEEF;
    step();
    ld_en[0] = 1'b0;
    cyc[0] = 1'b1; adr[0] = BASE + 32'h14;
    step(); chk("rd5_c1_ack", 32'(ack[0]), 32'd0);
    step(); chk("rd5_c2_ack", 32'(ack[0]), 32'd1);
    chk("rd5_rdt", rdt[0], 32'hDEAD_BEEF);
    chk("rd5_err", 32'(err[0]), 32'd0);
    step(); chk("rd5_pause_ack", 32'(ack[0]), 32'd0);
    chk("rd5_pause_rdt", rdt[0], 32'd0);
    cyc[0] = 1'b0;
    step();

    // A load to the word in flight during WAIT leaves the issued read data alone.
    cyc[0] = 1'b1; adr[0] = BASE + 32'h14;
    step();
    ld_en[0] = 1'b1; ld_adr[0] = 10'd5; ld_dat[0] = 32'h1111_1111;
    step(); chk("wcol_ack", 32'(ack[0]), 32'd1);
    chk("wcol_rdt_old", rdt[0], 32'hDEAD_BEEF);
    ld_en[0] = 1'b0; cyc[0] = 1'b0;
    step(); step();
    cyc[0] = 1'b1;
    step(); step(); chk("wcol_rdt_new", rdt[0], 32'h1111_1111);
    cyc[0] = 1'b0;
    step(); step();

    // Out of range above: BASE + 4 KiB.
    cyc[0] = 1'b1; adr[0] = BASE + 32'h1000;
    step(); step();
    chk("oor_hi_ack", 32'(ack[0]), 32'd1);
    chk("oor_hi_err", 32'(err[0]), 32'd1);
    chk("oor_hi_rdt", rdt[0], 32'd0);
    cyc[0] = 1'b0;
    step(); step();

    // Out of range below: BASE - 4.
    cyc[0] = 1'b1; adr[0] = BASE - 32'd4;
    step(); step();
    chk("oor_lo_ack", 32'(ack[0]), 32'd1);
    chk("oor_lo_err", 32'(err[0]), 32'd1);
    chk("oor_lo_rdt", rdt[0], 32'd0);
    cyc[0] = 1'b0;
    step(); step();

    // Zero wait states: ack the cycle after the request, then 3 cycles between acks.
    ld_en[1] = 1'b1; ld_adr[1] = 10'd0; ld_dat[1] = 32'h0000_0013;
    step();
    ld_en[1] = 1'b0;
    cyc[1] = 1'b1; adr[1] = BASE;
    step(); chk("ws0_ack1", 32'(ack[1]), 32'd1);
    chk("ws0_rdt1", rdt[1], 32'h0000_0013);
    chk("ws0_err1", 32'(err[1]), 32'd0);
    step(); chk("ws0_gap1", 32'(ack[1]), 32'd0);
    step(); chk("ws0_gap2", 32'(ack[1]), 32'd0);
    step(); chk("ws0_ack2", 32'(ack[1]), 32'd1);
    chk("ws0_rdt2", rdt[1], 32'h0000_0013);
    cyc[1] = 1'b0;
    step(); step();

    // Three wait states, with the request dropped after one cycle: no ack ever appears.
    cyc[2] = 1'b1; adr[2] = BASE;
    step();
    cyc[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_ack", 32'(ack[2]), 32'd0);
    end

    // Load and request together in IDLE: the write wins and the read starts a cycle later with new data.
    ld_en[2] = 1'b1; ld_adr[2] = 10'd7; ld_dat[2] = 32'hA5A5_0007;
    cyc[2] = 1'b1; adr[2] = BASE + 32'h1C;
    step();
    ld_en[2] = 1'b0;
    chk("col_c1_ack", 32'(ack[2]), 32'd0);
    step(); chk("col_c2_ack", 32'(ack[2]), 32'd0);
    step(); chk("col_c3_ack", 32'(ack[2]), 32'd0);
    step(); chk("col_c4_ack", 32'(ack[2]), 32'd0);
    step(); chk("col_c5_ack", 32'(ack[2]), 32'd1);
    chk("col_rdt", rdt[2], 32'hA5A5_0007);
    cyc[2] = 1'b0;
    step(); step();

    // Reset in the middle of WAIT: the request is abandoned and memory survives.
    cyc[2] = 1'b1; adr[2] = BASE + 32'h1C;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rstw_ack_now", 32'(ack[2]), 32'd0);
    chk("rstw_rdt_now", rdt[2], 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_ack_held", 32'(ack[2]), 32'd0);
    end
    rst_n = 1'b1;
    step(); chk("rstw_c1_ack", 32'(ack[2]), 32'd0);
    step(); chk("rstw_c2_ack", 32'(ack[2]), 32'd0);
    step(); chk("rstw_c3_ack", 32'(ack[2]), 32'd0);
    step(); chk("rstw_c4_ack", 32'(ack[2]), 32'd1);
    chk("rstw_rdt", rdt[2], 32'hA5A5_0007);
    cyc[2] = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
